// File: rtl/lsu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit. Holds the RISC-V
//            width codes, the FSM state type and the legality/alignment
//            helpers used when a request is accepted.
// Contents : LS_B/LS_H/LS_W/LS_BU/LS_HU   funct3 width codes
//            lsu_state_e                  controller state encoding
//            lsu_illegal()                unknown width or unsigned store
//            lsu_misaligned()             address not aligned to access size
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Unknown width codes are illegal; the unsigned variants exist only for loads.
  function automatic logic lsu_illegal(input logic i_we, input logic [2:0] i_funct3);
    logic r_bad;
    case (i_funct3)
      LS_B, LS_H, LS_W: r_bad = 1'b0;
      LS_BU, LS_HU:     r_bad = i_we;
      default:          r_bad = 1'b1;
    endcase
    return r_bad;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] i_funct3, input logic [1:0] i_addr_lo);
    logic r_mis;
    case (i_funct3)
      LS_H, LS_HU: r_mis = i_addr_lo[0];
      LS_W:        r_mis = |i_addr_lo;
      default:     r_mis = 1'b0;
    endcase
    return r_mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane logic. Extracts and extends the byte/half/word
//            lane of a memory word for loads, and merges store data into a
//            word for read-modify-write stores.
// Ports    : i_funct3   width code of the access
//            i_addr_lo  byte offset within the word
//            i_word     memory word (load source or merge base)
//            i_wdata    store data, low byte/halfword used for sub-word stores
//            o_load     extended load result
//            o_merged   i_word with the addressed lane replaced by store data
// Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_merged
);

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_mask;

  // Legal halfword/word offsets have their low bits clear, so one byte-granular
  // shift serves every width.
  assign w_shamt = {i_addr_lo, 3'b000};
  assign w_lane  = i_word >> w_shamt;

  always_comb begin
    o_load = w_lane;
    case (i_funct3)
      LS_B:    o_load = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      LS_H:    o_load = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      LS_BU:   o_load = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      LS_HU:   o_load = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      default: o_load = w_lane;
    endcase
  end

  always_comb begin
    w_mask = {XLEN{1'b1}};
    case (i_funct3)
      LS_B, LS_BU: w_mask = {{(XLEN-8){1'b0}}, 8'hFF} << w_shamt;
      LS_H, LS_HU: w_mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << w_shamt;
      default:     w_mask = {XLEN{1'b1}};
    endcase
  end

  assign o_merged = (i_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_rmw
// Purpose  : Load/store unit between execute and a word-organised data memory.
//            One request at a time; rejects illegal/misaligned accesses without
//            touching memory, extends sub-word loads, and performs sub-word
//            stores as a read-modify-write of the containing word.
// Ports    : clk_i, rst_i (async, active-high)
//            req_i/we_i/funct3_i/addr_i/wdata_i  request, sampled when ready_o
//            ready_o  idle      done_o  completion pulse
//            rdata_o  load data held until next done    err_o  bad request
//            mem_cs_n_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  memory
// Revision : 1.0  initial release
// ============================================================================
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            mem_cs_n_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  lsu_state_e      r_state;
  logic            r_we;
  logic            r_err;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_merge;

  logic            w_bad;
  logic            w_in_mem;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merged;

  assign w_bad = lsu_illegal(we_i, funct3_i) || lsu_misaligned(funct3_i, addr_i[1:0]);

  // The lane logic sees live memory data for loads and the captured word
  // while writing back a merged store.
  assign w_word = (r_state == ST_RMW_WR) ? r_merge : mem_rdata_i;

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (w_word),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merge  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_we     <= we_i;
            r_funct3 <= funct3_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_err    <= w_bad;
            if (w_bad)
              r_state <= ST_RESP;
            else if (we_i && (funct3_i != LS_W))
              r_state <= ST_RMW_RD;
            else
              r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_we)
            r_rdata <= w_load;
          r_state <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_merge <= mem_rdata_i;
          r_state <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_in_mem = (r_state == ST_ACCESS) || (r_state == ST_RMW_RD) || (r_state == ST_RMW_WR);

  assign ready_o    = (r_state == ST_IDLE);
  assign done_o     = (r_state == ST_RESP);
  assign err_o      = (r_state == ST_RESP) && r_err;
  assign rdata_o    = r_rdata;

  // Memory strobes decode straight from the state register, so an async reset
  // removes a pending write immediately.
  assign mem_cs_n_o = !w_in_mem;
  assign mem_we_o   = ((r_state == ST_ACCESS) && r_we) || (r_state == ST_RMW_WR);
  assign mem_addr_o = {r_addr[XLEN-1:2], 2'b00};

  always_comb begin
    mem_wdata_o = '0;
    case (r_state)
      ST_ACCESS: mem_wdata_o = r_we ? r_wdata : '0;
      ST_RMW_WR: mem_wdata_o = w_merged;
      default:   mem_wdata_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lsu_rmw
// Purpose  : Self-checking bench for lsu_rmw. A 64-word memory model sits on
//            the memory port; a byte-addressed reference memory predicts load
//            results, memory contents, latency and memory-cycle counts.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_rmw;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_cs_n_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  lsu_rmw #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_cs_n_o  (mem_cs_n_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Memory model with a preload port used only while the DUT is held in reset.
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'd0;
  int          wr_cnt = 0;

  assign mem_rdata_i = mem[mem_addr_o[7:2]];

  always @(posedge clk_i) begin
    if (pl_en)
      mem[pl_idx] <= pl_data;
    else if (!mem_cs_n_o && mem_we_o) begin
      mem[mem_addr_o[7:2]] <= mem_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Reference state
  logic [7:0]  ref_b [0:255];
  logic [31:0] exp_rdata = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  // One request: model prediction, drive, observe up to 8 cycles, compare.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int          size;
    int          ai;
    bit          legal;
    bit          e_err;
    int          e_lat;
    int          e_rd;
    int          e_wr;
    logic [31:0] v;
    int          lat;
    int          nrd;
    int          nwr;
    int          addr_bad;
    int          order_bad;
    bit          seen;
    logic        g_err;
    logic [31:0] g_rdata;

    ai    = int'(a[7:0]);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    e_err = !legal || ((ai % size) != 0);
    e_rd  = 0;
    e_wr  = 0;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      e_lat = 2;
      e_rd  = 1;
      v = 32'd0;
      for (int j = 0; j < size; j++)
        v = v | (32'(ref_b[ai+j]) << (8*j));
      if (!f3[2] && size < 4 && v[8*size-1])
        v = v | (32'hFFFF_FFFF << (8*size));
      exp_rdata = v;
    end else begin
      e_lat = (size == 4) ? 2 : 3;
      e_rd  = (size == 4) ? 0 : 1;
      e_wr  = 1;
      for (int j = 0; j < size; j++)
        ref_b[ai+j] = wd[8*j +: 8];
    end

    @(negedge clk_i);
    chk("ready_before_req", 32'(ready_o), 32'd1);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    @(posedge clk_i);
    seen = 0; lat = 0; nrd = 0; nwr = 0; addr_bad = 0; order_bad = 0;
    g_err = 1'b0; g_rdata = 32'd0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        // The unit must rely only on its latched copy from here on.
        req_i = 1'b0; we_i = 1'($urandom); funct3_i = 3'($urandom);
        addr_i = $urandom; wdata_i = $urandom;
      end
      if (mem_cs_n_o && mem_we_o) addr_bad++;
      if (!mem_cs_n_o) begin
        if (mem_addr_o !== {a[31:2], 2'b00}) addr_bad++;
        if (mem_we_o) nwr++;
        else begin
          nrd++;
          if (nwr > 0) order_bad++;
        end
      end
      if (done_o) begin
        seen = 1; lat = k; g_err = err_o; g_rdata = rdata_o;
      end
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("err", 32'(g_err), 32'(e_err));
    chk("rdata", g_rdata, exp_rdata);
    chk("mem_reads", 32'(nrd), 32'(e_rd));
    chk("mem_writes", 32'(nwr), 32'(e_wr));
    chk("mem_addr_strobe_errs", 32'(addr_bad + order_bad), 32'd0);
    if (we && !e_err)
      chk("mem_word", mem[a[7:2]], ref_word(ai & ~3));
  endtask

  int          d1;
  int          d2;
  int          wr0;
  int          done_seen;
  int          we_seen;
  logic [31:0] word0;
  logic [31:0] v0;

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;

    // Preload memory and mirror it into the byte reference
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      v0 = (i == 16) ? 32'h8899_AABB : $urandom;
      pl_en = 1'b1; pl_idx = 6'(i); pl_data = v0;
      for (int j = 0; j < 4; j++)
        ref_b[4*i+j] = v0[8*j +: 8];
    end
    @(negedge clk_i);
    pl_en = 1'b0;

    // Reset values
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_cs_n", 32'(mem_cs_n_o), 32'd1);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;

    // Directed vectors on word 0x40 = 0x8899AABB
    run_req(1'b0, 3'b000, 32'h43, 32'd0);
    chk("tp_lb", rdata_o, 32'hFFFF_FF88);
    run_req(1'b0, 3'b100, 32'h43, 32'd0);
    chk("tp_lbu", rdata_o, 32'h0000_0088);
    run_req(1'b0, 3'b001, 32'h42, 32'd0);
    chk("tp_lh", rdata_o, 32'hFFFF_8899);
    run_req(1'b0, 3'b010, 32'h41, 32'd0);
    chk("tp_lw_mis_rdata_held", rdata_o, 32'hFFFF_8899);
    run_req(1'b1, 3'b000, 32'h41, 32'h1234_5677);
    chk("tp_sb_word", mem[16], 32'h8899_77BB);
    run_req(1'b0, 3'b010, 32'h40, 32'd0);
    chk("tp_lw_after_sb", rdata_o, 32'h8899_77BB);
    run_req(1'b1, 3'b010, 32'h80, 32'hDEAD_BEEF);
    chk("tp_sw_word", mem[32], 32'hDEAD_BEEF);
    wr0 = wr_cnt;
    run_req(1'b1, 3'b001, 32'h83, 32'h0000_5555);
    chk("tp_sh_mis_nowrite", 32'(wr_cnt - wr0), 32'd0);

    // Back-to-back with req_i held high
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h00; wdata_i = 32'd0;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 20 && d2 < 0; k++) begin
      @(negedge clk_i);
      if (k == 1) addr_i = 32'h04;
      if (done_o) begin
        if (d1 < 0) begin
          d1 = k;
          chk("b2b_rdata0", rdata_o, ref_word(0));
        end else begin
          d2 = k;
          req_i = 1'b0;
          chk("b2b_rdata1", rdata_o, ref_word(4));
        end
      end
    end
    req_i = 1'b0;
    chk("b2b_spacing", 32'(d2 - d1), 32'd3);
    exp_rdata = ref_word(4);

    // Reset during RMW_RD of an SB
    @(negedge clk_i);
    chk("rr_ready", 32'(ready_o), 32'd1);
    word0 = mem[17];
    wr0 = wr_cnt;
    req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h45; wdata_i = 32'hCAFE_F00D;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    chk("rr_in_read", 32'({mem_cs_n_o, mem_we_o}), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("rr_we_async", 32'(mem_we_o), 32'd0);
    chk("rr_cs_async", 32'(mem_cs_n_o), 32'd1);
    done_seen = 0; we_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (done_o) done_seen++;
      if (mem_we_o) we_seen++;
    end
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (done_o) done_seen++;
      if (mem_we_o) we_seen++;
    end
    chk("rr_no_done_no_we", 32'(done_seen + we_seen), 32'd0);
    chk("rr_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("rr_word_kept", mem[17], word0);
    chk("rr_ready_after", 32'(ready_o), 32'd1);
    chk("rr_err", 32'(err_o), 32'd0);
    chk("rr_rdata", rdata_o, 32'd0);
    chk("rr_mem_addr", mem_addr_o, 32'd0);
    chk("rr_mem_wdata", mem_wdata_o, 32'd0);
    exp_rdata = 32'd0;

    // Randomized traffic
    for (int n = 0; n < 200; n++)
      run_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
